// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) using radix-2 restoring division.
// Produces one quotient bit per cycle and handshakes through start/busy/wb_valid.
module div_unit #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic [RD_W-1:0] rd_in,
  output logic            busy,
  output logic            wb_valid,
  output logic [RD_W-1:0] wb_rd,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            op_rem_q, op_rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            busy_q, busy_d;
  logic            wb_valid_q, wb_valid_d;
  logic [RD_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            is_signed_s, a_neg_s, b_neg_s, div_zero_s, overflow_s, ge_s;
  logic [XLEN-1:0] a_abs_s, b_abs_s, special_res_s;
  logic [XLEN:0]   rem_shift_s;
  logic [XLEN-1:0] rem_step_s, quo_step_s, rem_fix_s, quo_fix_s;

  assign busy     = busy_q;
  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign result   = result_q;

  // Operand conditioning, special-case detection and one restoring-division step
  always_comb begin
    is_signed_s = ~funct3[0];
    a_neg_s     = is_signed_s & dividend[XLEN-1];
    b_neg_s     = is_signed_s & divisor[XLEN-1];
    a_abs_s     = a_neg_s ? -dividend : dividend;
    b_abs_s     = b_neg_s ? -divisor : divisor;
    div_zero_s  = (divisor == ZERO);
    overflow_s  = is_signed_s & (dividend == MIN_NEG) & (divisor == ALL_ONES);
    if (div_zero_s) begin
      special_res_s = funct3[1] ? dividend : ALL_ONES;
    end else if (overflow_s) begin
      special_res_s = funct3[1] ? ZERO : MIN_NEG;
    end else begin
      special_res_s = ZERO;
    end

    // Remainder is always below the divisor, so the XLEN-bit difference is exact
    rem_shift_s = {rem_q, quo_q[XLEN-1]};
    ge_s        = (rem_shift_s >= {1'b0, dvs_q});
    rem_step_s  = ge_s ? (rem_shift_s[XLEN-1:0] - dvs_q) : rem_shift_s[XLEN-1:0];
    quo_step_s  = {quo_q[XLEN-2:0], ge_s};
    quo_fix_s   = neg_quo_q ? -quo_step_s : quo_step_s;
    rem_fix_s   = neg_rem_q ? -rem_step_s : rem_step_s;
  end

  // Next-state and output computation for the IDLE/CALC/DONE sequencer
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    op_rem_d   = op_rem_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    busy_d     = busy_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    result_d   = result_q;
    case (state_q)
      IDLE: begin
        if (start && !flush && funct3[2]) begin
          op_rem_d  = funct3[1];
          neg_quo_d = a_neg_s ^ b_neg_s;
          neg_rem_d = a_neg_s;
          wb_rd_d   = rd_in;
          busy_d    = 1'b1;
          quo_d     = a_abs_s;
          dvs_d     = b_abs_s;
          rem_d     = ZERO;
          count_d   = {CW{1'b0}};
          if (div_zero_s || overflow_s) begin
            state_d    = DONE;
            result_d   = special_res_s;
            wb_valid_d = 1'b1;
          end else begin
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          rem_d   = rem_step_s;
          quo_d   = quo_step_s;
          count_d = count_q + CNT_ONE;
          if (count_q == LAST_CNT) begin
            state_d    = DONE;
            wb_valid_d = 1'b1;
            result_d   = op_rem_q ? rem_fix_s : quo_fix_s;
          end else begin
            state_d = CALC;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= {CW{1'b0}};
      rem_q      <= ZERO;
      quo_q      <= ZERO;
      dvs_q      <= ZERO;
      op_rem_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      busy_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= {RD_W{1'b0}};
      result_q   <= ZERO;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      op_rem_q   <= op_rem_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      busy_q     <= busy_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      result_q   <= result_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, random ops against an
// arithmetic reference model, and handshake/flush/reset sequences.
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [4:0]  rd_in;
  logic        busy;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  div_unit #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .funct3(funct3),
    .dividend(dividend), .divisor(divisor), .rd_in(rd_in),
    .busy(busy), .wb_valid(wb_valid), .wb_rd(wb_rd), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // RISC-V M-extension semantics in plain arithmetic
  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return f3[1] ? 32'd0 : 32'h8000_0000;
    case (f3)
      3'b100:  return sa / sb;
      3'b101:  return a / b;
      3'b110:  return sa % sb;
      default: return a % b;
    endcase
  endfunction

  // Issue one op from an idle DUT; returns #1 after the edge following wb_valid
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp);
    int lat;
    logic special;
    special = (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    funct3 = f3; dividend = a; divisor = b; rd_in = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_at_accept", {31'd0, busy}, 32'd1);
    lat = 0;
    while (!wb_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency_edges", lat, special ? 32'd0 : 32'd32);
    chk("result", result, exp);
    chk("wb_rd", {27'd0, wb_rd}, {27'd0, rd});
    chk("busy_in_done", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("wb_valid_pulse_end", {31'd0, wb_valid}, 32'd0);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int pulses;
    int busy_seen;
    logic [31:0] saved;
    logic [31:0] ra, rb, sel;
    logic [2:0]  rf;

    vecs[0]  = '{3'b101, 32'd100,        32'd7,        32'd14};
    vecs[1]  = '{3'b111, 32'd100,        32'd7,        32'd2};
    vecs[2]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF};
    vecs[3]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD};
    vecs[4]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    vecs[5]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
    vecs[6]  = '{3'b101, 32'd5,          32'd0,        32'hFFFF_FFFF};
    vecs[7]  = '{3'b111, 32'd5,          32'd0,        32'd5};
    vecs[8]  = '{3'b100, 32'd7,          32'd0,        32'hFFFF_FFFF};
    vecs[9]  = '{3'b110, 32'hFFFF_FFF9,  32'd0,        32'hFFFF_FFF9};
    vecs[10] = '{3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD};
    vecs[11] = '{3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1};
    vecs[12] = '{3'b101, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF};
    vecs[13] = '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
    vecs[14] = '{3'b111, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    vecs[15] = '{3'b100, 32'h8000_0000,  32'd2,        32'hC000_0000};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = 3'b000;
    dividend = 32'd0; divisor = 32'd0; rd_in = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("reset_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("reset_result", result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].exp);
    end

    for (int i = 0; i < 40; i++) begin
      rf  = {1'b1, 2'($urandom_range(0, 3))};
      sel = $urandom_range(0, 9);
      ra  = $urandom;
      rb  = $urandom;
      if (sel == 32'd0) rb = 32'd0;
      else if (sel == 32'd1) rb = 32'($urandom_range(1, 15));
      else if (sel == 32'd2) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 32'd3) rb = ra >> $urandom_range(0, 31);
      else rb = rb >> $urandom_range(0, 24);
      run_op(rf, ra, rb, 5'($urandom_range(0, 31)), ref_div(rf, ra, rb));
    end

    // start with funct3[2]=0 is not an M op
    funct3 = 3'b010; dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("non_m_ignored", {31'd0, busy}, 32'd0);

    // flush beats start in IDLE
    funct3 = 3'b101; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start_idle", {31'd0, busy}, 32'd0);

    // starts during busy are dropped, exactly one writeback
    funct3 = 3'b101; dividend = 32'd1000; divisor = 32'd10; rd_in = 5'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0;
    for (int c = 1; c < 60; c++) begin
      if (c == 3 || c == 10) begin
        start = 1'b1; rd_in = 5'd9; dividend = 32'd50; divisor = 32'd5;
      end else begin
        start = 1'b0;
      end
      if (wb_valid) begin
        pulses++;
        chk("busy_start_rd", {27'd0, wb_rd}, 32'd7);
        chk("busy_start_result", result, 32'd100);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("busy_start_pulses", pulses, 32'd1);

    // flush at count 15
    saved = result;
    funct3 = 3'b101; dividend = 32'hFFFF_FFFF; divisor = 32'd3; rd_in = 5'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("flush_result_held", result, saved);
    run_op(3'b101, 32'd9, 32'd3, 5'd6, 32'd3);

    // async reset mid-CALC
    funct3 = 3'b100; dividend = 32'd12345; divisor = 32'd11; rd_in = 5'd12; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("async_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("async_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    busy_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (wb_valid) pulses++;
      if (busy) busy_seen++;
    end
    chk("post_reset_pulses", pulses, 32'd0);
    chk("post_reset_busy", busy_seen, 32'd0);
    run_op(3'b110, 32'd12345, 32'd11, 5'd12, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
